// File: rtl/pixel_unpack_pkg.sv
// -----------------------------------------------------------------------------
// pixel_unpack_pkg
//   Shared definitions for the pixel unpacker slice:
//     - default geometry and word/pixel widths
//     - lanes_of()  : pixels per FIFO word
//     - cnt_width() : clog2-based counter width, never less than 1 bit
//     - pix_flags_t : position flags bundle produced by pixel_pos_counter
// -----------------------------------------------------------------------------
package pixel_unpack_pkg;

    localparam int unsigned DEF_WORD_WIDTH  = 256;
    localparam int unsigned DEF_PIXEL_WIDTH = 16;
    localparam int unsigned DEF_N_COL       = 2048;
    localparam int unsigned DEF_N_ROW       = 2048;
    localparam int unsigned STARVE_W        = 16;

    // Number of pixel lanes carried by one FIFO word.
    function automatic int unsigned lanes_of(input int unsigned word_w,
                                             input int unsigned pix_w);
        return word_w / pix_w;
    endfunction

    // Width of a counter spanning 0..n-1; a one-value counter still gets a bit
    // so that no zero-width vector is ever declared.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } pix_flags_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// -----------------------------------------------------------------------------
// pixel_pos_counter
//   Column/row tracker for the unpacked pixel stream. Advances once per
//   accepted pixel, wraps at the end of each line and frame, and decodes the
//   start/end of line/frame flags from the current position.
//
// Ports
//   CLK     in   clock
//   RESET   in   synchronous active-high reset (position -> 0,0)
//   clear   in   frame restart (position -> 0,0), lower priority than RESET
//   enable  in   pixel transfer strobe, advances the position
//   flags   out  sof/eof/sol/eol decoded from the current position
// -----------------------------------------------------------------------------
module pixel_pos_counter
    import pixel_unpack_pkg::*;
#(
    parameter int unsigned N_COL = DEF_N_COL,
    parameter int unsigned N_ROW = DEF_N_ROW
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       enable,
    output pix_flags_t flags
);

    localparam int unsigned COL_W = cnt_width(N_COL);
    localparam int unsigned ROW_W = cnt_width(N_ROW);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROW - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_wrap;
    logic             row_wrap;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        flags     = '0;
        flags.sol = (col == '0);
        flags.eol = col_wrap;
        flags.sof = (col == '0) && (row == '0);
        flags.eof = col_wrap && row_wrap;
    end

endmodule

// File: rtl/pixel_unpack.sv
// -----------------------------------------------------------------------------
// pixel_unpack
//   Splits wide words from a first-word-fall-through FIFO into a stream of
//   pixels, lane 0 (LSB slice) first, with valid/ready handshaking and
//   start/end of line/frame flags. Lines are not word aligned, so one word
//   may straddle an end-of-line or end-of-frame boundary.
//
//   The next word is popped in the same cycle the last lane is accepted, so
//   consecutive words stream with no bubble while pix_ready stays high.
//
// Ports
//   CLK          in   sole clock
//   RESET        in   synchronous active-high reset
//   fifo_empty   in   upstream FIFO empty (fifo_dout valid when low)
//   fifo_dout    in   upstream head word, WORD_WIDTH bits
//   fifo_rden    out  pop head word (combinational)
//   frame_start  in   one-cycle pulse: restart frame, drop the held word
//   pix_ready    in   downstream accepts the current pixel
//   pix_valid    out  pixel valid
//   pix_data     out  pixel value, PIXEL_WIDTH bits
//   pix_sof/eof/sol/eol out  position flags, forced low when pix_valid is low
//   starve_cnt   out  16-bit starvation counter
//
// Build option
//   PIXEL_UNPACK_STARVE_CNT_EN: when defined, starve_cnt counts (saturating)
//   cycles with no pixel held, an empty FIFO and a frame in progress; when
//   undefined starve_cnt is constant zero and no counter exists.
//
//   DELAY is kept on the parameter list for drop-in compatibility with
//   behavioural models; this implementation models no intra-cycle delay.
// -----------------------------------------------------------------------------
module pixel_unpack
    import pixel_unpack_pkg::*;
#(
    parameter int unsigned DELAY       = 1,
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int unsigned N_COL       = DEF_N_COL,
    parameter int unsigned N_ROW       = DEF_N_ROW
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   fifo_empty,
    input  logic [WORD_WIDTH-1:0]  fifo_dout,
    output logic                   fifo_rden,
    input  logic                   frame_start,
    input  logic                   pix_ready,
    output logic                   pix_valid,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_sof,
    output logic                   pix_eof,
    output logic                   pix_sol,
    output logic                   pix_eol,
    output logic [STARVE_W-1:0]    starve_cnt
);

    localparam int unsigned LANES  = lanes_of(WORD_WIDTH, PIXEL_WIDTH);
    localparam int unsigned LANE_W = cnt_width(LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    // Reject geometries the datapath cannot represent.
    if (LANES < 2 || (WORD_WIDTH % PIXEL_WIDTH) != 0 || N_COL < 1 || N_ROW < 1
        || DELAY > 1000) begin : g_bad_params
        $error("pixel_unpack: invalid parameter combination");
    end

    logic [WORD_WIDTH-1:0]             word_q;
    logic [LANES-1:0][PIXEL_WIDTH-1:0] word_lanes;
    logic                              have_word;
    logic [LANE_W-1:0]                 lane;
    logic                              last_lane;
    logic                              xfer;
    pix_flags_t                        pos_flags;

    assign last_lane = (lane == LANE_LAST);
    assign xfer      = have_word && pix_ready;

    // Pop when idle, or when the last lane leaves this cycle so the next word
    // is in place for the following cycle.
    assign fifo_rden = !RESET && !fifo_empty && !frame_start &&
                       (!have_word || (last_lane && pix_ready));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_q    <= '0;
            have_word <= 1'b0;
            lane      <= '0;
        end else if (frame_start) begin
            have_word <= 1'b0;
            lane      <= '0;
        end else if (fifo_rden) begin
            word_q    <= fifo_dout;
            have_word <= 1'b1;
            lane      <= '0;
        end else if (xfer) begin
            if (last_lane) begin
                have_word <= 1'b0;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

    assign word_lanes = word_q;
    assign pix_data   = word_lanes[lane];
    assign pix_valid  = have_word;

    pixel_pos_counter #(
        .N_COL (N_COL),
        .N_ROW (N_ROW)
    ) u_pos (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (frame_start),
        .enable (xfer),
        .flags  (pos_flags)
    );

    // Flags only mean something alongside a valid pixel; hold them low
    // otherwise so an idle or freshly reset block drives all zeros.
    assign pix_sof = have_word && pos_flags.sof;
    assign pix_eof = have_word && pos_flags.eof;
    assign pix_sol = have_word && pos_flags.sol;
    assign pix_eol = have_word && pos_flags.eol;

`ifdef PIXEL_UNPACK_STARVE_CNT_EN
    logic [STARVE_W-1:0] starve_q;
    logic                starving;

    // Position 0,0 (sof) means no frame is in progress yet, so waiting there
    // is not starvation.
    assign starving = !have_word && fifo_empty && !pos_flags.sof;

    always_ff @(posedge CLK) begin
        if (RESET || frame_start) begin
            starve_q <= '0;
        end else if (starving && (starve_q != '1)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign starve_cnt = starve_q;
`else
    assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_unpack.sv
module tb_pixel_unpack;

    localparam int WW = 64;
    localparam int PW = 16;
    localparam int LN = WW / PW;
    localparam int NC = 6;
    localparam int NR = 2;
`ifdef PIXEL_UNPACK_STARVE_CNT_EN
    localparam int STARVE_EXP = 10;
`else
    localparam int STARVE_EXP = 0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          fifo_empty;
    logic [WW-1:0] fifo_dout;
    logic          fifo_rden;
    logic          frame_start;
    logic          pix_ready;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_sof, pix_eof, pix_sol, pix_eol;
    logic [15:0]   starve_cnt;

    int checks   = 0;
    int errors   = 0;
    int idx      = 0;   // pixels accepted since frame start (reference position)
    int rden_cnt = 0;

    logic [WW-1:0] fifo_q[$];   // upstream FIFO model
    logic [PW-1:0] exp_q[$];    // scoreboard of expected pixels

    always #5 CLK = ~CLK;

    pixel_unpack #(
        .DELAY       (1),
        .WORD_WIDTH  (WW),
        .PIXEL_WIDTH (PW),
        .N_COL       (NC),
        .N_ROW       (NR)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rden   (fifo_rden),
        .frame_start (frame_start),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eof     (pix_eof),
        .pix_sol     (pix_sol),
        .pix_eol     (pix_eol),
        .starve_cnt  (starve_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    endtask

    function automatic logic [WW-1:0] mk_word(input logic [15:0] base);
        logic [WW-1:0] w;
        for (int i = 0; i < LN; i++) w[i*PW +: PW] = base + 16'(i);
        return w;
    endfunction

    task automatic push_word(input logic [WW-1:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < LN; i++) exp_q.push_back(w[i*PW +: PW]);
        fifo_sync();
    endtask

    // Drops the untransferred remainder of the held word from the scoreboard.
    task automatic discard_held();
        int n;
        n = exp_q.size() - LN * fifo_q.size();
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        idx = 0;
    endtask

    // One clock: compare the presented pixel before the edge, model the
    // FIFO pop at the edge, and return just after the falling edge.
    task automatic step();
        logic rd;
        int   c, r;
        #1;
        if (pix_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", pix_valid, 0);
            end else begin
                c = idx % NC;
                r = (idx / NC) % NR;
                check("pix_data", pix_data, exp_q[0]);
                check("pix_sol", pix_sol, (c == 0));
                check("pix_eol", pix_eol, (c == NC - 1));
                check("pix_sof", pix_sof, (c == 0 && r == 0));
                check("pix_eof", pix_eof, (c == NC - 1 && r == NR - 1));
                if (pix_ready) begin
                    void'(exp_q.pop_front());
                    idx++;
                end
            end
        end
        rd = fifo_rden;
        if (rd === 1'b1) rden_cnt++;
        @(posedge CLK);
        if (rd === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        @(negedge CLK);
        fifo_sync();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        RESET       = 1'b1;
        frame_start = 1'b0;
        pix_ready   = 1'b1;
        fifo_sync();
        repeat (2) @(negedge CLK);

        // Reset state
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_sof", pix_sof, 0);
        check("rst_sol", pix_sol, 0);
        check("rst_starve", starve_cnt, 0);
        check("rst_rden", fifo_rden, 0);

        // Word arrives while still in reset: no pop
        push_word(64'h0004_0003_0002_0001);
        #1;
        check("rden_in_reset", fifo_rden, 0);
        step();
        RESET    = 1'b0;
        rden_cnt = 0;

        // Single word, latency 1, pixels 1..4
        #1;
        check("first_rden", fifo_rden, 1);
        check("first_valid_t", pix_valid, 0);
        step();
        #1;
        check("first_valid_t1", pix_valid, 1);
        check("first_data_t1", pix_data, 16'h0001);
        drain("word1");
        check("word1_rden_cnt", rden_cnt, 1);

        // Two queued words stream with no bubble; second pop with lane 3
        push_word(mk_word(16'h0100));
        push_word(mk_word(16'h0200));
        #1;
        check("b2b_rden0", fifo_rden, 1);
        step();
        for (int k = 0; k < 2 * LN; k++) begin
            #1;
            check("b2b_valid", pix_valid, 1);
            check("b2b_rden", fifo_rden, ((k % LN) == LN - 1) && (k < LN));
            step();
        end
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_idle", pix_valid, 0);

        // Stall at lane 2 for 5 cycles, next word already queued
        push_word(mk_word(16'h0300));
        push_word(mk_word(16'h0400));
        step();
        step();
        step();
        pix_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_valid", pix_valid, 1);
            check("stall_rden", fifo_rden, 0);
            check("stall_data", pix_data, 16'h0302);
            step();
        end
        pix_ready = 1'b1;
        drain("stall");

        // frame_start at lane 1 with the FIFO non-empty
        push_word(mk_word(16'h0500));
        push_word(mk_word(16'h0600));
        step();
        step();
        pix_ready   = 1'b0;
        frame_start = 1'b1;
        #1;
        check("fs_rden_held", fifo_rden, 0);
        step();
        frame_start = 1'b0;
        discard_held();
        #1;
        check("fs_valid", pix_valid, 0);
        check("fs_sof_masked", pix_sof, 0);
        // Idle with data waiting: frame_start must still block the pop
        frame_start = 1'b1;
        #1;
        check("fs_rden_idle", fifo_rden, 0);
        step();
        frame_start = 1'b0;
        discard_held();
        pix_ready = 1'b1;
        #1;
        check("fs_rden_after", fifo_rden, 1);
        drain("after_fs");

        // Starvation mid-frame for 10 cycles
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        discard_held();
        #1;
        check("starve_clr", starve_cnt, 0);
        push_word(mk_word(16'h0700));
        drain("starve_word");
        repeat (10) step();
        #1;
        check("starve_cnt", starve_cnt, STARVE_EXP);

        // Reset in the middle of a word
        push_word(mk_word(16'h0800));
        push_word(mk_word(16'h0900));
        step();
        step();
        pix_ready = 1'b0;
        RESET     = 1'b1;
        step();
        RESET = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_sync();
        idx = 0;
        #1;
        check("mrst_valid", pix_valid, 0);
        check("mrst_data", pix_data, 0);
        check("mrst_flags", {pix_sof, pix_eof, pix_sol, pix_eol}, 0);
        check("mrst_starve", starve_cnt, 0);
        check("mrst_rden", fifo_rden, 0);

        // Recovery: new word starts a fresh frame
        pix_ready = 1'b1;
        push_word(mk_word(16'h0A00));
        drain("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_unpack.md
PIXEL_UNPACK -- requirements
Module: pixel_unpack

Interface
REQ-001 Parameter DELAY, default 1, simulation delay on all registered assignments.
REQ-002 Parameter WORD_WIDTH, default 256, FIFO read-word width.
REQ-003 Parameter PIXEL_WIDTH, default 16, pixel width; WORD_WIDTH SHALL be an integer multiple (LANES = WORD_WIDTH/PIXEL_WIDTH, LANES >= 2).
REQ-004 Parameters N_COL, default 2048, and N_ROW, default 2048, frame geometry in pixels.
REQ-005 Port list (one clock; reset is synchronous and active-high):
- CLK  in  1  sole clock.
- RESET  in  1  synchronous active-high reset.
- fifo_empty  in  1  upstream FWFT FIFO empty; fifo_dout is valid when low.
- fifo_dout  in  WORD_WIDTH  upstream head word.
- fifo_rden  out  1  pop upstream head word.
- frame_start  in  1  one-cycle pulse: restart frame, discard held word.
- pix_ready  in  1  downstream accepts pixel.
- pix_valid  out  1  pixel valid.
- pix_data  out  PIXEL_WIDTH  pixel value.
- pix_sof / pix_eof / pix_sol / pix_eol  out  1 each  position flags, qualified by pix_valid.
- starve_cnt  out  16  starvation counter (REQ-019).

Function
REQ-006 Block SHALL hold one word register, a have_word flag and a lane index 0..LANES-1.
REQ-007 pix_data SHALL be lane slice [lane*PIXEL_WIDTH +: PIXEL_WIDTH]; lane 0 is the LSB slice.
REQ-008 pix_valid SHALL equal have_word; a pixel transfers when pix_valid && pix_ready.
REQ-009 fifo_rden SHALL be combinational: !fifo_empty && !frame_start && (!have_word || (lane==LANES-1 && pix_ready)).
REQ-010 On fifo_rden, word register SHALL load fifo_dout, lane SHALL become 0, have_word SHALL become 1.
REQ-011 On transfer of lane LANES-1 without fifo_rden, have_word SHALL clear; otherwise a transfer increments lane.
REQ-012 Latency: word visible (fifo_empty low) at cycle t with block idle -> pix_valid at t+1; back-to-back words SHALL stream with zero bubbles while pix_ready is high.
REQ-013 pix_ready low SHALL freeze pix_data, lane, position counters and flags.
REQ-014 Column counter 0..N_COL-1 and row counter 0..N_ROW-1 SHALL advance on each transfer; col wraps to 0 and increments row; row N_ROW-1 col N_COL-1 wraps both to 0.
REQ-015 Flags: pix_sol = col==0; pix_eol = col==N_COL-1; pix_sof = row==0 && col==0; pix_eof = row==N_ROW-1 && col==N_COL-1.
REQ-016 Lines SHALL not be word-aligned: a word MAY span an EOL or EOF boundary.
REQ-017 frame_start SHALL, next cycle, clear have_word, lane, col and row; priority RESET > frame_start > transfer/load; fifo_rden SHALL be low during frame_start.

Reset
REQ-018 On RESET: fifo_rden low (combinationally, REQ-009 gated by RESET), pix_valid 0, pix_data 0, word register 0, lane 0, col 0, row 0, starve_cnt 0; effective next cycle regardless of activity.

Configuration
REQ-019 With PIXEL_UNPACK_STARVE_CNT_EN defined: starve_cnt SHALL increment, saturating at 16'hFFFF, each cycle where !have_word && fifo_empty && (row|col) != 0; cleared by RESET and frame_start.
REQ-020 Without PIXEL_UNPACK_STARVE_CNT_EN: starve_cnt SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-021 LANES and log2 helper (clog2 for lane/col/row widths) SHALL live in the shared function include/package; geometry defaults in the shared pixel package.
REQ-022 Position tracking (col/row counters, flags) SHALL be sub-module pixel_pos_counter, enabled by the transfer strobe and cleared by frame_start.

Verification
REQ-023 LANES=4, PIXEL_WIDTH=16, word 64'h0004_0003_0002_0001, pix_ready high -> pix_data 1,2,3,4 on cycles t+1..t+4, one fifo_rden.
REQ-024 Two words queued, pix_ready high -> 8 consecutive valid pixels, second fifo_rden coincident with lane-3 transfer, no bubble.
REQ-025 pix_ready low for 5 cycles at lane 2 -> pix_data/flags held, no fifo_rden; resumes with lane 2.
REQ-026 N_COL=6, N_ROW=2, LANES=4 -> pix_eol on pixels 6 and 12, pix_eof on 12, pix_sof on 13 (word 4 lane 0).
REQ-027 frame_start at lane 1 with fifo non-empty -> next cycle pix_valid 0, counters 0, fifo_rden low that cycle; next word restarts at pix_sof.
REQ-028 RESET mid-word and, with PIXEL_UNPACK_STARVE_CNT_EN, fifo empty 10 cycles mid-frame -> starve_cnt 10; after RESET all outputs 0.
